// File: rtl/accumulator_array.sv
// accumulator_array: NPROC adder workers reduce a LIFO operand pool to a single sum.
// Workers pop two words, add them (ADD_LAT cycles) and push the sum back; one pool
// port is shared through a round-robin arbiter that serves reads and writes alike.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   load_valid/_data  - operand offered for the pool; load_ready accepts it
//   start             - begin reduction (LOAD or DONE phase)
//   busy, done        - REDUCE / DONE phase indicators
//   result, overflow  - final sum and sticky carry-out flag for the current run
//   count             - words currently in the pool
//   grant             - one-hot pool-port grant for this cycle (zero when idle)
module accumulator_array #(
  parameter int unsigned NPROC   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [DATA_W-1:0]        load_data,
  output logic                     load_ready,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W-1:0]        result,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic [NPROC-1:0]         grant
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (NPROC > 1) ? $clog2(NPROC) : 1;
  localparam int unsigned LW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {PH_LOAD, PH_REDUCE, PH_DONE} phase_t;
  typedef enum logic [1:0] {W_IDLE, W_ADD, W_WR} wstate_t;

  phase_t              phase;
  wstate_t             wst     [NPROC];
  logic [LW-1:0]       lat_cnt [NPROC];
  logic [DATA_W-1:0]   opa     [NPROC];
  logic [DATA_W-1:0]   opb     [NPROC];
  logic [DATA_W-1:0]   sum     [NPROC];
  logic [DATA_W:0]     add_full[NPROC];
  logic [DATA_W-1:0]   pool    [DEPTH];
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       ptr_next;
  logic [PW-1:0]       gnt_idx;
  logic                gnt_any;
  logic [NPROC-1:0]    req;
  logic                all_idle;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DATA_W-1:0]   wr_data;

  // Accept loads while filling, and in DONE where a load starts a fresh pool.
  assign load_ready = ((phase == PH_LOAD) && (count < DEPTH_C)) || (phase == PH_DONE);

  // Worker requests: reads need two words, writes are always eligible.
  always_comb begin
    req      = '0;
    all_idle = 1'b1;
    for (int i = 0; i < int'(NPROC); i++) begin
      if (wst[i] != W_IDLE) all_idle = 1'b0;
      if (phase == PH_REDUCE) begin
        req[i] = ((wst[i] == W_IDLE) && (count >= CW'(2))) || (wst[i] == W_WR);
      end
    end
  end

  // Full-width adders; the extra bit is the carry-out.
  always_comb begin
    for (int i = 0; i < int'(NPROC); i++) begin
      add_full[i] = {1'b0, opa[i]} + {1'b0, opb[i]};
    end
  end

  // Round-robin arbiter: first requester at or after ptr wins.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    ptr_next = ptr;
    for (int k = 0; k < int'(NPROC); k++) begin
      idx = (int'(ptr) + k) % int'(NPROC);
      if (!gnt_any && req[PW'(idx)]) begin
        gnt_any         = 1'b1;
        gnt_idx         = PW'(idx);
        grant[PW'(idx)] = 1'b1;
      end
    end
    if (gnt_any) begin
      ptr_next = (gnt_idx == PW'(NPROC - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  // Single pool write port: loads in LOAD/DONE, worker pushes in REDUCE.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = AW'(count);
    wr_data = load_data;
    case (phase)
      PH_LOAD:   wr_en = load_valid && (count < DEPTH_C);
      PH_DONE: begin
        wr_en   = load_valid;
        wr_addr = '0;
      end
      PH_REDUCE: begin
        wr_en   = gnt_any && (wst[gnt_idx] == W_WR);
        wr_data = sum[gnt_idx];
      end
      default: wr_en = 1'b0;
    endcase
  end

  // Pool storage carries no reset; count defines which words are live.
  always_ff @(posedge clk) begin
    if (wr_en) pool[wr_addr] <= wr_data;
  end

  // Phase control, worker FSMs, count and arbiter pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= PH_LOAD;
      count    <= '0;
      result   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ptr      <= '0;
      for (int i = 0; i < int'(NPROC); i++) begin
        wst[i]     <= W_IDLE;
        lat_cnt[i] <= '0;
        opa[i]     <= '0;
        opb[i]     <= '0;
        sum[i]     <= '0;
      end
    end else begin
      case (phase)
        PH_LOAD: begin
          if (load_valid && (count < DEPTH_C)) count <= count + CW'(1);
          if (start) begin
            phase    <= PH_REDUCE;
            busy     <= 1'b1;
            overflow <= 1'b0;
          end
        end
        PH_DONE: begin
          // A load discards the old pool; start (if also present) runs on the new one.
          if (load_valid) begin
            count <= CW'(1);
            phase <= PH_LOAD;
            done  <= 1'b0;
          end
          if (start) begin
            phase    <= PH_REDUCE;
            busy     <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        PH_REDUCE: begin
          if ((count <= CW'(1)) && all_idle) begin
            phase  <= PH_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= (count == CW'(1)) ? pool[0] : '0;
          end
          if (gnt_any) begin
            ptr <= ptr_next;
            if (wst[gnt_idx] == W_IDLE) count <= count - CW'(2);
            else                        count <= count + CW'(1);
          end
          for (int i = 0; i < int'(NPROC); i++) begin
            case (wst[i])
              W_IDLE: begin
                if (grant[i]) begin
                  opa[i]     <= pool[AW'(count - CW'(1))];
                  opb[i]     <= pool[AW'(count - CW'(2))];
                  lat_cnt[i] <= '0;
                  wst[i]     <= W_ADD;
                end
              end
              W_ADD: begin
                if (lat_cnt[i] == LW'(ADD_LAT - 1)) begin
                  sum[i] <= add_full[i][DATA_W-1:0];
                  if (add_full[i][DATA_W]) overflow <= 1'b1;
                  wst[i] <= W_WR;
                end else begin
                  lat_cnt[i] <= lat_cnt[i] + LW'(1);
                end
              end
              W_WR: begin
                if (grant[i]) wst[i] <= W_IDLE;
              end
              default: wst[i] <= W_IDLE;
            endcase
          end
        end
        default: phase <= PH_LOAD;
      endcase
    end
  end

endmodule

// File: doc/accumulator_array.md
# accumulator_array

Parametrised successor of the four-processor parallel accumulator. The block holds an internal operand pool of up to `DEPTH` words and a run-time-loaded set of values. `NPROC` identical adder workers share one pool port through a round-robin arbiter and repeatedly pop two words, add them and push the sum back until a single word remains. That word is the result. Everything runs on one clock domain, and the block replaces the separate bus/processor clocks and tri-state shared bus with a muxed single-port arbitration.

## Interface
Parameters:
- `NPROC`, default 4: number of adder workers, legal range 1..8.
- `DATA_W`, default 32: operand, sum and result width.
- `DEPTH`, default 16: pool capacity in words, a power of 2 and at least 2.
- `ADD_LAT`, default 1: cycles each worker spends in ADD, legal range 1..4.

Ports:
- `clk` in 1: the single clock, rising-edge.
- `reset` in 1: synchronous, active-high; clears all state on the clock edge.
- `load_valid` in 1: `load_data` is offered this cycle.
- `load_data` in `DATA_W`: operand to push into the pool.
- `load_ready` out 1: a load is accepted this cycle when `load_valid && load_ready`.
- `start` in 1: single-cycle request to begin reduction.
- `busy` out 1: high while in REDUCE.
- `done` out 1: high while in DONE; `result` is valid.
- `result` out `DATA_W`: final sum.
- `overflow` out 1: sticky flag; some addition carried out of `DATA_W` bits during the current run.
- `count` out clog2(`DEPTH`)+1: number of words in the pool.
- `grant` out `NPROC`: one-hot pool-port grant for the current cycle; all zero when no grant.

## Operation
Top-level phases are LOAD, REDUCE and DONE.

- **Reset:** phase LOAD, `count`=0, `result`=0, `overflow`=0, `done`=0, `busy`=0, `grant`=0, all workers IDLE, arbiter pointer=0.
- **LOAD:** `load_ready = (count < DEPTH)`.
  - An accepted word is written to pool[`count`] and `count`++.
  - `load_valid` while `count==DEPTH` is dropped, with no error.
  - `start` moves the phase to REDUCE and clears `overflow`. If `start` and a load occur in the same cycle, the load is taken first.
- **REDUCE:** `load_ready`=0; `load_valid` and `start` are ignored. The pool is LIFO.
- **Worker FSM:**
  - IDLE: requests a read. The request is eligible only when `count >= 2`. On grant, the worker latches pool[`count`-1] and pool[`count`-2], `count` -= 2, and it goes to ADD.
  - ADD: holds for `ADD_LAT` cycles, then forms `sum = a + b` mod 2^`DATA_W`. A carry-out sets `overflow`. The worker then goes to WR.
  - WR: requests a write, which is always eligible. On grant it writes pool[`count`] = sum, `count`++, and returns to IDLE.
- **Arbiter:**
  - Grants at most one eligible request per cycle. Reads and writes share the same round-robin.
  - The search starts at the pointer index. After a grant to worker i, the pointer becomes (i+1) mod `NPROC`.
  - With no grant, the pointer is unchanged.
- **Termination:** when `count <= 1` and all workers are IDLE, the next edge enters DONE. `result` = pool[0] if `count==1`, else 0.
  - Each completed reduction lowers `count` by exactly 1, and reads require 2 words, so the block cannot deadlock.
- **DONE:**
  - `done`=1 and `result` is held. `load_ready`=1.
  - The first accepted load clears the pool (`count` becomes 1 with that word) and returns to LOAD; `done` falls.
  - `start` in DONE re-runs reduction on the existing pool.
- **Reset in any phase or worker state** aborts the run: in-flight sums are lost and all reset values are restored on that edge.

## Timing
- Loads: pool write and `count` update take effect on the accepting edge. `load_ready` is combinational from phase and `count`.
- `grant` is combinational from registered worker states, `count` and the pointer. Pop and push commit on the same edge.
- `busy` rises on the edge after `start` is sampled.
- Minimum latency (`NPROC`=1, `ADD_LAT`=1, 2 words): `start`@T0; read grant@T1; ADD@T2; write grant@T3; IDLE with `count`=1@T4; `done`=1@T5.
- General per-worker loop: 1 (read) + `ADD_LAT` + 1 (write) cycles, plus any arbitration wait.
- `start` with `count`=0 gives `done`@T2 and `result`=0. With `count`=1 it gives `done`@T2 and `result` = that word.

## Test plan
- **Reset:** assert `reset` mid-REDUCE with `NPROC`=4 and 8 words loaded → the next cycle shows `count`=0, `busy`=0, `done`=0, `grant`=0 and `load_ready`=1.
- **Basic sum:** `NPROC`=4, load 3, 5, 7, 9, then `start` → `done`=1 with `result`=24 and `overflow`=0. Check that `grant` is one-hot or zero every cycle and that no two consecutive grants go to the same worker while others are requesting.
- **Overflow:** `DATA_W`=8, load 200, 100, then `start` → `result`=44 and `overflow`=1. Then load 1, 2 and `start` → `overflow`=0 and `result`=3.
- **Full pool:** `DEPTH`=16, offer 17 words valued 1..17 → `load_ready`=0 once `count`=16, and the 17th word is dropped. After `start`, `result`=136.
- **Latency and edge cases:** with `NPROC`=1 and `ADD_LAT`=1, load 2 words and `start`@T0 → `done`@T5. `start` with empty pool → `done`@T2 with `result`=0. `start` with one word 42 → `result`=42.
- **Ignored inputs and restart:** `load_valid` and `start` pulses during REDUCE are ignored and `count` is unaffected. A load in DONE restarts with `count`=1.
